// File: rtl/bpsk_demodulator.sv
// -----------------------------------------------------------------------------
// bpsk_demodulator
// Coherent BPSK receiver built around a decision-directed Costas loop.
// A phase-accumulator NCO addresses an external cosine LUT twice per clk: once
// for the in-phase carrier and once a quarter period earlier for the
// quadrature (sine) carrier. Received samples are mixed with both carriers,
// low-pass filtered per arm, and the arm outputs drive a PI loop filter that
// steers the NCO. The sign of the in-phase arm is the recovered bit.
//
// Pipeline: data_in -> mix (stage 1) -> lpf (stage 2) -> data_out (stage 3).
//
// Ports
//   clk                          system clock
//   rst_n                        asynchronous active-low reset
//   data_in                      signed received sample (Q2.FRAC_W), one per clk
//   data_out                     recovered bit, 1 when the in-phase arm is >= 0
//   nco_i_cosine_lu_angle_steps  LUT address of the in-phase carrier
//   nco_q_cosine_lu_angle_steps  LUT address of the quadrature carrier
//   nco_carrier_i                cos(addr_i) returned combinationally by the LUT
//   nco_carrier_q                cos(addr_q) returned combinationally by the LUT
// -----------------------------------------------------------------------------
module bpsk_demodulator #(
   parameter int DATA_W    = 16,
   parameter int FRAC_W    = DATA_W - 2,
   parameter int N_SAMP    = 64,
   parameter int PHASE_W   = $clog2(N_SAMP),
   parameter int PH_FRAC   = 16,
   parameter int LPF_SHIFT = 3,
   parameter int KP_SHIFT  = 4,
   parameter int KI_SHIFT  = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] data_in,
   output logic                     data_out,
   output logic [PHASE_W-1:0]       nco_i_cosine_lu_angle_steps,
   output logic [PHASE_W-1:0]       nco_q_cosine_lu_angle_steps,
   input  logic signed [DATA_W-1:0] nco_carrier_i,
   input  logic signed [DATA_W-1:0] nco_carrier_q
);

   localparam int ACC_W   = PHASE_W + PH_FRAC;
   localparam int PROD_W  = 2 * DATA_W;
   localparam int LPF_W   = DATA_W + LPF_SHIFT;
   localparam int INTEG_W = 32;
   localparam int SUM_W   = INTEG_W + 1;

   localparam logic [ACC_W-1:0]   FCW     = ACC_W'((N_SAMP / 8) << PH_FRAC);
   localparam logic [PHASE_W-1:0] QUARTER = PHASE_W'(N_SAMP / 4);

   localparam logic signed [DATA_W-1:0]  S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0]  S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [PROD_W-1:0]  W_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0]  W_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [INTEG_W-1:0] I_MAX = {1'b0, {(INTEG_W-1){1'b1}}};
   localparam logic signed [INTEG_W-1:0] I_MIN = {1'b1, {(INTEG_W-1){1'b0}}};

   // Clamp a wide signed value into the DATA_W sample range.
   function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [PROD_W-1:0] v);
      logic signed [DATA_W-1:0] r;
      if (v > W_MAX) begin
         r = S_MAX;
      end else if (v < W_MIN) begin
         r = S_MIN;
      end else begin
         r = v[DATA_W-1:0];
      end
      return r;
   endfunction

   // One IIR update lpf + (mix - lpf)/2^LPF_SHIFT with LPF_SHIFT guard bits.
   function automatic logic signed [DATA_W-1:0] lpf_step(input logic signed [DATA_W-1:0] mix,
                                                         input logic signed [DATA_W-1:0] lpf);
      logic signed [LPF_W-1:0] diff;
      logic signed [LPF_W-1:0] sum;
      diff = LPF_W'(mix) - LPF_W'(lpf);
      sum  = LPF_W'(lpf) + (diff >>> LPF_SHIFT);
      return sat_data(PROD_W'(sum));
   endfunction

   logic [ACC_W-1:0]          phase_acc_q, phase_acc_d;
   logic signed [DATA_W-1:0]  mix_i_q, mix_i_d, mix_q_q, mix_q_d;
   logic signed [DATA_W-1:0]  lpf_i_q, lpf_i_d, lpf_q_q, lpf_q_d;
   logic signed [INTEG_W-1:0] integ_q, integ_d;
   logic                      data_out_q, data_out_d;

   logic signed [PROD_W-1:0]  prod_i_s, prod_q_s;
   logic signed [DATA_W-1:0]  err_s;
   logic signed [ACC_W-1:0]   ctrl_s;
   logic signed [SUM_W-1:0]   integ_sum_s;

   // Quadrature address trails the in-phase one by a quarter period, so the LUT returns sin.
   assign nco_i_cosine_lu_angle_steps = phase_acc_q[ACC_W-1 -: PHASE_W];
   assign nco_q_cosine_lu_angle_steps = phase_acc_q[ACC_W-1 -: PHASE_W] - QUARTER;
   assign data_out                    = data_out_q;

   // Datapath: mixer products, arm filters and the bit decision.
   always_comb begin
      prod_i_s   = PROD_W'(data_in) * PROD_W'(nco_carrier_i);
      prod_q_s   = PROD_W'(data_in) * PROD_W'(nco_carrier_q);
      mix_i_d    = sat_data(prod_i_s >>> FRAC_W);
      mix_q_d    = sat_data(prod_q_s >>> FRAC_W);
      lpf_i_d    = lpf_step(mix_i_q, lpf_i_q);
      lpf_q_d    = lpf_step(mix_q_q, lpf_q_q);
      data_out_d = ~lpf_i_q[DATA_W-1];
   end

   // Costas phase detector, PI loop filter and NCO phase update.
   always_comb begin
      // Decision-directed error; negating the most negative value would wrap, so clamp it.
      if (lpf_i_q[DATA_W-1] == 1'b0) begin
         err_s = lpf_q_q;
      end else if (lpf_q_q == S_MIN) begin
         err_s = S_MAX;
      end else begin
         err_s = -lpf_q_q;
      end

      integ_sum_s = SUM_W'(integ_q) + SUM_W'(err_s >>> KI_SHIFT);
      if (integ_sum_s[SUM_W-1] != integ_sum_s[SUM_W-2]) begin
         integ_d = integ_sum_s[SUM_W-1] ? I_MIN : I_MAX;
      end else begin
         integ_d = integ_sum_s[INTEG_W-1:0];
      end

      // Phase wraps modulo 2^ACC_W, so only the low ACC_W bits of ctrl matter.
      ctrl_s      = ACC_W'(err_s >>> KP_SHIFT) + ACC_W'(integ_q);
      phase_acc_d = phase_acc_q + FCW + $unsigned(ctrl_s);
   end

   // State registers for NCO, mixer, arm filters, loop integrator and decision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_acc_q <= {ACC_W{1'b0}};
         mix_i_q     <= {DATA_W{1'b0}};
         mix_q_q     <= {DATA_W{1'b0}};
         lpf_i_q     <= {DATA_W{1'b0}};
         lpf_q_q     <= {DATA_W{1'b0}};
         integ_q     <= {INTEG_W{1'b0}};
         data_out_q  <= 1'b0;
      end else begin
         phase_acc_q <= phase_acc_d;
         mix_i_q     <= mix_i_d;
         mix_q_q     <= mix_q_d;
         lpf_i_q     <= lpf_i_d;
         lpf_q_q     <= lpf_q_d;
         integ_q     <= integ_d;
         data_out_q  <= data_out_d;
      end
   end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// -----------------------------------------------------------------------------
// tb_bpsk_demodulator
// Self-checking bench for bpsk_demodulator. Provides the cosine LUT, drives
// random and BPSK-shaped samples, and compares the DUT against an arithmetic
// reference of the receiver kept in plain integers (floor division, clamping,
// modulo phase). Also checks NCO stepping, bit recovery, saturation and
// asynchronous reset against fixed expected values.
// -----------------------------------------------------------------------------
module tb_bpsk_demodulator;

   localparam int     DATA_W  = 16;
   localparam int     N_SAMP  = 64;
   localparam int     PHASE_W = 6;
   localparam longint PH_ONE  = 64'sd65536;
   localparam longint ACC_MOD = 64'sd4194304;
   localparam longint FCW     = (N_SAMP / 8) * PH_ONE;
   localparam longint ONE_Q   = 64'sd16384;
   localparam longint S_MAX   = 64'sd32767;
   localparam longint S_MIN   = -64'sd32768;
   localparam longint I_MAX   = 64'sd2147483647;
   localparam longint I_MIN   = -64'sd2147483648;

   logic                     clk;
   logic                     rst_n;
   logic signed [DATA_W-1:0] data_in;
   logic                     data_out;
   logic [PHASE_W-1:0]       addr_i;
   logic [PHASE_W-1:0]       addr_q;
   logic signed [DATA_W-1:0] carrier_i;
   logic signed [DATA_W-1:0] carrier_q;

   logic signed [DATA_W-1:0] lut_mem [0:N_SAMP-1];
   logic                     ovr_en;
   logic signed [DATA_W-1:0] ovr_val;

   int n_checks;
   int n_fail;

   // reference model state
   longint m_phase, m_mix_i, m_mix_q, m_lpf_i, m_lpf_q, m_integ, m_dout;

   bpsk_demodulator #(
      .DATA_W (DATA_W),
      .N_SAMP (N_SAMP)
   ) dut (
      .clk                         (clk),
      .rst_n                       (rst_n),
      .data_in                     (data_in),
      .data_out                    (data_out),
      .nco_i_cosine_lu_angle_steps (addr_i),
      .nco_q_cosine_lu_angle_steps (addr_q),
      .nco_carrier_i               (carrier_i),
      .nco_carrier_q               (carrier_q)
   );

   assign carrier_i = ovr_en ? ovr_val : lut_mem[addr_i];
   assign carrier_q = ovr_en ? ovr_val : lut_mem[addr_q];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint fdiv(input longint a, input longint d);
      return (a >= 0) ? a / d : -((-a + d - 64'sd1) / d);
   endfunction

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   function automatic longint m_ai();
      return m_phase / PH_ONE;
   endfunction

   function automatic longint m_aq();
      return (m_ai() + N_SAMP - N_SAMP / 4) % N_SAMP;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_mix_i = 0; m_mix_q = 0;
      m_lpf_i = 0; m_lpf_q = 0; m_integ = 0; m_dout = 0;
   endtask

   // Advance the reference by one clock given the sample presented this cycle.
   task automatic model_step(input longint x);
      longint ci, cq, err, ctrl, n_mix_i, n_mix_q, n_lpf_i, n_lpf_q, n_integ, n_dout;
      ci      = ovr_en ? longint'(ovr_val) : longint'(lut_mem[m_ai()]);
      cq      = ovr_en ? longint'(ovr_val) : longint'(lut_mem[m_aq()]);
      n_mix_i = clamp(fdiv(x * ci, ONE_Q), S_MIN, S_MAX);
      n_mix_q = clamp(fdiv(x * cq, ONE_Q), S_MIN, S_MAX);
      n_lpf_i = clamp(m_lpf_i + fdiv(m_mix_i - m_lpf_i, 64'sd8), S_MIN, S_MAX);
      n_lpf_q = clamp(m_lpf_q + fdiv(m_mix_q - m_lpf_q, 64'sd8), S_MIN, S_MAX);
      err     = (m_lpf_i >= 0) ? m_lpf_q : -m_lpf_q;
      err     = clamp(err, S_MIN, S_MAX);
      n_integ = clamp(m_integ + fdiv(err, 64'sd1024), I_MIN, I_MAX);
      ctrl    = fdiv(err, 64'sd16) + m_integ;
      m_phase = ((m_phase + FCW + ctrl) % ACC_MOD + ACC_MOD) % ACC_MOD;
      n_dout  = (m_lpf_i >= 0) ? 64'sd1 : 64'sd0;
      m_mix_i = n_mix_i; m_mix_q = n_mix_q;
      m_lpf_i = n_lpf_i; m_lpf_q = n_lpf_q;
      m_integ = n_integ; m_dout  = n_dout;
   endtask

   // Drive one sample at the falling edge, let the rising edge take it, compare.
   task automatic step(input logic signed [DATA_W-1:0] x);
      data_in = x;
      model_step(longint'(x));
      @(negedge clk);
      check_eq("addr_i", longint'(addr_i), m_ai());
      check_eq("addr_q", longint'(addr_q), m_aq());
      check_eq("data_out", longint'(data_out), m_dout);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_dout"}, longint'(data_out), 64'sd0);
      check_eq({tag, "_addr_i"}, longint'(addr_i), 64'sd0);
      check_eq({tag, "_addr_q"}, longint'(addr_q), longint'(3 * N_SAMP / 4));
   endtask

   // Pulse reset for one clock starting just after a falling edge.
   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("rst_async");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic signed [DATA_W-1:0] r;
      longint hv;
      int     b;
      real    v;

      n_checks = 0;
      n_fail   = 0;
      ovr_en   = 1'b0;
      ovr_val  = 16'sd0;
      data_in  = 16'sd0;
      rst_n    = 1'b0;
      for (int k = 0; k < N_SAMP; k++) begin
         v = $cos(2.0 * 3.14159265358979 * k / N_SAMP) * 16384.0;
         lut_mem[k] = (v >= 0.0) ? 16'($rtoi(v + 0.5)) : 16'(-$rtoi(-v + 0.5));
      end
      model_reset();

      // reset state, then NCO free-runs at N_SAMP/8 per clk with zero input
      @(negedge clk);
      check_reset_outputs("rst_init");
      rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step(16'sd0);
         check_eq("nco_step", longint'(addr_i), longint'((k * (N_SAMP / 8)) % N_SAMP));
      end

      // random samples against the reference
      for (int k = 0; k < 250; k++) begin
         r = 16'($urandom);
         step(r);
      end

      // in-phase BPSK at half scale built from the NCO's own carrier; random bits
      pulse_reset();
      for (int p = 0; p < 10; p++) begin
         b = int'($urandom_range(0, 1));
         for (int j = 0; j < 20; j++) begin
            hv = longint'(lut_mem[m_ai()]) / 64'sd2;
            step((b == 1) ? 16'(hv) : 16'(-hv));
            if (j == 19) check_eq("bit_follow", longint'(data_out), longint'(b));
         end
      end

      // full-scale saturation: carrier = MIN, input = MIN then MAX
      ovr_en  = 1'b1;
      ovr_val = -16'sd32768;
      for (int k = 0; k < 40; k++) step(-16'sd32768);
      check_eq("sat_pos_bit", longint'(data_out), 64'sd1);
      for (int k = 0; k < 40; k++) step(16'sd32767);
      check_eq("sat_neg_bit", longint'(data_out), 64'sd0);
      ovr_en = 1'b0;

      // mid-stream reset clears everything, then operation resumes
      for (int k = 0; k < 20; k++) begin
         r = 16'($urandom);
         step(r);
      end
      pulse_reset();
      check_reset_outputs("rst_release");
      step(16'sd0);
      check_eq("post_rst_step", longint'(addr_i), longint'(N_SAMP / 8));
      for (int k = 0; k < 150; k++) begin
         r = 16'($urandom);
         step(r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
